// File: rtl/draw_pkg.sv
// ---------------------------------------------------------------------------
// draw_pkg
// Shared definitions for the VGA object-draw path: the scheduler state
// encoding, the pass encoding (erase vs. draw) and the slot numbers that the
// game-state logic uses to place the player, enemies and bullet into the
// obj_active mask.
// Ports: none (package only).
// ---------------------------------------------------------------------------
package draw_pkg;

   // Scheduler states: IDLE between frames, SCAN inspects one slot per cycle,
   // ISSUE pulses draw_start, WAIT holds the command until the drawer is done.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      ISSUE = 2'd2,
      WAIT  = 2'd3
   } sched_state_t;

   // ERASE redraws last frame's objects in background colour, DRAW renders
   // this frame's objects.
   typedef enum logic {
      DRAW  = 1'b0,
      ERASE = 1'b1
   } pass_t;

   // Slot numbers shared with the game-state logic.
   localparam int PLAYER = 0;
   localparam int ENEMY1 = 1;
   localparam int ENEMY2 = 2;
   localparam int ENEMY3 = 3;
   localparam int ENEMY4 = 4;
   localparam int BULLET = 5;

endpackage

// File: rtl/draw_scheduler.sv
// ---------------------------------------------------------------------------
// draw_scheduler
// Walks the sprite slots once per frame and hands each active slot to the
// shared pixel drawer with a start/done handshake. With ERASE_PASS set, the
// slots that were active last frame are first redrawn in background colour.
//
// Ports:
//   clk           : system clock, rising edge
//   reset         : synchronous, active-high
//   frame_start   : one-cycle frame request (from vsync)
//   obj_active    : per-slot active mask, captured when a frame starts
//   draw_start    : one-cycle command to the drawer for obj_id
//   obj_id        : slot being drawn, stable until draw_done is accepted
//   erase         : current command is an erase (background colour)
//   draw_done     : one-cycle completion pulse from the drawer
//   busy          : scheduler is working on a frame
//   frame_done    : one-cycle pulse in the first idle cycle after a frame
//   frame_overrun : one-cycle pulse after a frame_start that arrived while busy
// ---------------------------------------------------------------------------
module draw_scheduler
   import draw_pkg::*;
#(
   parameter int NUM_OBJ    = 6,
   parameter int ID_W       = $clog2(NUM_OBJ),
   parameter bit ERASE_PASS = 1'b1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               frame_start,
   input  logic [NUM_OBJ-1:0] obj_active,
   output logic               draw_start,
   output logic [ID_W-1:0]    obj_id,
   output logic               erase,
   input  logic               draw_done,
   output logic               busy,
   output logic               frame_done,
   output logic               frame_overrun
);

   localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NUM_OBJ - 1);

   sched_state_t       state;
   pass_t              pass;
   logic [ID_W-1:0]    idx;
   logic [NUM_OBJ-1:0] cur_mask;
   logic [NUM_OBJ-1:0] prev_mask;
   logic               frame_done_q;
   logic               frame_overrun_q;

   logic [NUM_OBJ-1:0] pass_mask;
   logic               slot_hit;
   logic               advance;

   // Select which snapshot the current pass walks, and decide whether the
   // current slot is finished: in SCAN an inactive slot is finished at once,
   // in WAIT the slot is finished when the drawer reports done. draw_done in
   // any other state is deliberately ignored.
   always_comb begin
      pass_mask = (pass == ERASE) ? prev_mask : cur_mask;
      slot_hit  = pass_mask[idx];
      advance   = 1'b0;
      if (state == SCAN) begin
         advance = !slot_hit;
      end else if (state == WAIT) begin
         advance = draw_done;
      end
   end

   // Frame sequencer. Finishing a slot either steps to the next one or, on
   // the last slot, ends the pass: the erase pass rolls straight into the
   // draw pass, the draw pass commits this frame's mask as next frame's erase
   // list and returns to IDLE with a frame_done pulse. A frame_start seen
   // outside IDLE never disturbs the frame; it only raises frame_overrun.
   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= IDLE;
         pass            <= DRAW;
         idx             <= '0;
         cur_mask        <= '0;
         prev_mask       <= '0;
         frame_done_q    <= 1'b0;
         frame_overrun_q <= 1'b0;
      end else begin
         frame_done_q    <= 1'b0;
         frame_overrun_q <= frame_start && (state != IDLE);
         case (state)
            IDLE: begin
               if (frame_start) begin
                  cur_mask <= obj_active;
                  idx      <= '0;
                  if (ERASE_PASS) begin
                     pass <= ERASE;
                  end else begin
                     pass <= DRAW;
                  end
                  state <= SCAN;
               end
            end
            SCAN, WAIT: begin
               if (advance) begin
                  if (idx == LAST_IDX) begin
                     if (pass == ERASE) begin
                        pass  <= DRAW;
                        idx   <= '0;
                        state <= SCAN;
                     end else begin
                        prev_mask    <= cur_mask;
                        state        <= IDLE;
                        frame_done_q <= 1'b1;
                     end
                  end else begin
                     idx   <= idx + ID_W'(1);
                     state <= SCAN;
                  end
               end else if (state == SCAN) begin
                  state <= ISSUE;
               end
            end
            ISSUE: begin
               state <= WAIT;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Every output is a direct decode of the registers above.
   assign draw_start    = (state == ISSUE);
   assign obj_id        = idx;
   assign erase         = (pass == ERASE);
   assign busy          = (state != IDLE);
   assign frame_done    = frame_done_q;
   assign frame_overrun = frame_overrun_q;

endmodule
